mcu_core_param: RTL and testbench

Parametrised multicycle MCU core, the next-generation successor of the lab5 core. It keeps the 16-bit instruction format, the 16-entry register file and the IF/ID/FD/EX/RWB sequence. It adds configurable data and PC width, a writable instruction memory for program load, run/single-step control, Z/C flags, a BZ branch and a debug register read port. It sits below the board top-level, which drives run/step from switches and displays pc/w_reg/alu_out/opcode.

---
 rtl/mcu_core_param.sv | 182 ++++++++++++++++++
 tb/tb_mcu_core_param.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_core_param.sv
// Parametrised multicycle MCU core: 16-bit instructions, 16 x DW register file, IF/ID/FD/EX/RWB.
// Define MCU_MULDIV_EN to build the MUL/DIV datapath; without it opcodes 5/6 retire as NOPs.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for run or step; imem writable
// IF    | IR <= imem[pc]
// ID    | decode slot
// FD    | A <= RF[RA], B <= RF[RB]
// EX    | w_reg <= alu_out, carry captured
// RWB   | RF/flag write-back, pc update, retire
// HLT   | stopped by opcode 0 until reset; imem writable
module mcu_core_param #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          step,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_addr,
    input  logic [15:0]   imem_wdata,
    input  logic [3:0]    dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [AW-1:0] pc,
    output logic [3:0]    opcode,
    output logic [DW-1:0] alu_out,
    output logic [DW-1:0] w_reg,
    output logic          zflag,
    output logic          cflag,
    output logic          busy,
    output logic          halted,
    output logic          retire
);

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_FD, S_EX, S_RWB, S_HLT
    } state_t;

    state_t        state;
    logic [15:0]   ir;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic          c_pend;
    logic [DW-1:0] rf [16];
    logic [15:0]   imem [0:(1<<AW)-1];

    logic [3:0]    ra;
    logic [3:0]    rb;
    logic [3:0]    rd;
    logic [7:0]    imm8;
    logic          alu_c;
    logic [DW:0]   sum_ext;
    logic          rf_wr;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_rel;
    logic [AW-1:0] pc_nxt;

    assign opcode   = ir[15:12];
    assign ra       = ir[11:8];
    assign rb       = ir[7:4];
    assign rd       = ir[3:0];
    assign imm8     = ir[11:4];
    assign dbg_data = rf[dbg_addr];
    assign busy     = (state != S_IDLE) && (state != S_HLT);
    assign halted   = (state == S_HLT);
    assign retire   = (state == S_RWB);

    // Program load is only accepted while the core is not executing.
    always_ff @(posedge clk) begin
        if (!reset && imem_we && (state == S_IDLE || state == S_HLT))
            imem[imem_addr] <= imem_wdata;
    end

    always_comb begin
        alu_out = '0;
        alu_c   = 1'b0;
        sum_ext = '0;
        case (opcode)
            4'd1: alu_out = DW'(imm8);
            4'd2: begin
                sum_ext = {1'b0, a_reg} + {1'b0, b_reg};
                alu_out = sum_ext[DW-1:0];
                alu_c   = sum_ext[DW];
            end
            4'd3: begin
                sum_ext = {1'b0, a_reg} + (DW+1)'(rb);
                alu_out = sum_ext[DW-1:0];
                alu_c   = sum_ext[DW];
            end
            4'd4: begin
                alu_out = a_reg - b_reg;
                alu_c   = (a_reg < b_reg);
            end
`ifdef MCU_MULDIV_EN
            4'd5: alu_out = a_reg * b_reg;
            4'd6: alu_out = (b_reg == '0) ? '1 : a_reg / b_reg;
`endif
            4'd7:  alu_out = b_reg + DW'(1);
            4'd8:  alu_out = b_reg - DW'(1);
            4'd9:  alu_out = ~(a_reg | b_reg);
            4'd10: alu_out = ~(a_reg & b_reg);
            4'd11: alu_out = a_reg ^ b_reg;
            4'd12: alu_out = ~b_reg;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        rf_wr = (opcode >= 4'd1) && (opcode <= 4'd12);
`ifndef MCU_MULDIV_EN
        if (opcode == 4'd5 || opcode == 4'd6)
            rf_wr = 1'b0;
`endif
    end

    // BZ looks at the flag as it stands before this write-back; BZ never writes flags.
    always_comb begin
        pc_inc = pc + AW'(1);
        pc_rel = pc + AW'(rd);
        case (opcode)
            4'd0:    pc_nxt = pc;
            4'd13:   pc_nxt = AW'(imm8);
            4'd14:   pc_nxt = (a_reg >= b_reg) ? pc_rel : pc_inc;
            4'd15:   pc_nxt = zflag ? pc_rel : pc_inc;
            default: pc_nxt = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            w_reg  <= '0;
            c_pend <= 1'b0;
            zflag  <= 1'b0;
            cflag  <= 1'b0;
            for (int i = 0; i < 16; i++)
                rf[i] <= '0;
        end else begin
            case (state)
                S_IDLE: if (run || step) state <= S_IF;
                S_IF: begin
                    ir    <= imem[pc];
                    state <= S_ID;
                end
                S_ID: state <= S_FD;
                S_FD: begin
                    a_reg <= rf[ra];
                    b_reg <= rf[rb];
                    state <= S_EX;
                end
                S_EX: begin
                    w_reg  <= alu_out;
                    c_pend <= alu_c;
                    state  <= S_RWB;
                end
                S_RWB: begin
                    if (rf_wr) begin
                        rf[rd] <= w_reg;
                        zflag  <= (w_reg == '0);
                        cflag  <= c_pend;
                    end
                    pc <= pc_nxt;
                    if (opcode == 4'd0)
                        state <= S_HLT;
                    else if (run)
                        state <= S_IF;
                    else
                        state <= S_IDLE;
                end
                S_HLT: state <= S_HLT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_core_param.sv
// Self-checking bench for mcu_core_param (DW=8, AW=8): vector table, directed sequences,
// and random programs stepped against an instruction-level reference model.
`timescale 1ns/1ps

module tb_mcu_core_param;
    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          imem_we = 1'b0;
    logic [AW-1:0] imem_addr = '0;
    logic [15:0]   imem_wdata = '0;
    logic [3:0]    dbg_addr = '0;
    logic [DW-1:0] dbg_data;
    logic [AW-1:0] pc;
    logic [3:0]    opcode;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] w_reg;
    logic          zflag, cflag, busy, halted, retire;

    mcu_core_param #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc(pc), .opcode(opcode),
        .alu_out(alu_out), .w_reg(w_reg), .zflag(zflag), .cflag(cflag),
        .busy(busy), .halted(halted), .retire(retire)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_imem [256];
    logic [7:0]  m_rf [16];
    int          m_pc;
    logic        m_z, m_c;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] ir;
        logic [7:0]  rd;
        logic        z;
        logic        c;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input int addr, input logic [15:0] data);
        imem_we    = 1'b1;
        imem_addr  = AW'(addr);
        imem_wdata = data;
        tick();
        imem_we    = 1'b0;
        m_imem[addr] = data;
    endtask

    task automatic rd_reg(input int idx, output logic [7:0] val);
        dbg_addr = 4'(idx);
        #1;
        val = dbg_data;
    endtask

    task automatic chk_reg(input string name, input int idx, input logic [7:0] exp);
        logic [7:0] v;
        rd_reg(idx, v);
        chk(name, 32'(v), 32'(exp));
    endtask

    task automatic run_to_halt(input string name);
        run = 1'b1;
        for (int i = 0; i < 200 && !halted; i++) tick();
        run = 1'b0;
        chk({name, "_halt"}, 32'(halted), 32'd1);
    endtask

    task automatic step_one(output int nret);
        step = 1'b1;
        tick();
        step = 1'b0;
        nret = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (retire) nret++;
        end
    endtask

    // Reference: one instruction from the architectural rules, plain integer arithmetic.
    task automatic model_exec();
        logic [15:0] ir;
        int op, ra, rb, rd, a, b, res, npc;
        logic c, wr;
        ir = m_imem[m_pc];
        op = int'(ir[15:12]); ra = int'(ir[11:8]); rb = int'(ir[7:4]); rd = int'(ir[3:0]);
        a = int'(m_rf[ra]); b = int'(m_rf[rb]);
        res = 0; c = 1'b0; wr = (op >= 1 && op <= 12);
        case (op)
            1:  res = ra * 16 + rb;
            2:  begin res = a + b; c = (res > 255); end
            3:  begin res = a + rb; c = (res > 255); end
            4:  begin res = a - b; c = (a < b); end
`ifdef MCU_MULDIV_EN
            5:  res = a * b;
            6:  res = (b == 0) ? 255 : a / b;
`else
            5, 6: wr = 1'b0;
`endif
            7:  res = b + 1;
            8:  res = b - 1;
            9:  res = 255 - (a | b);
            10: res = 255 - (a & b);
            11: res = a ^ b;
            12: res = 255 - b;
            default: res = 0;
        endcase
        res = res & 255;
        case (op)
            0:  npc = m_pc;
            13: npc = ra * 16 + rb;
            14: npc = (a >= b) ? m_pc + rd : m_pc + 1;
            15: npc = m_z ? m_pc + rd : m_pc + 1;
            default: npc = m_pc + 1;
        endcase
        if (wr) begin
            m_rf[rd] = 8'(res);
            m_z = (res == 0);
            m_c = c;
        end
        m_pc = npc % 256;
    endtask

    initial begin
        logic [7:0] v;
        int rcyc[$];
        int nret;

        vt[0]  = '{8'h05, 8'h03, 16'h2123, 8'h08, 1'b0, 1'b0};
        vt[1]  = '{8'hFF, 8'h01, 16'h2123, 8'h00, 1'b1, 1'b1};
        vt[2]  = '{8'hF5, 8'h00, 16'h31F3, 8'h04, 1'b0, 1'b1};
        vt[3]  = '{8'h03, 8'h05, 16'h4123, 8'hFE, 1'b0, 1'b1};
        vt[4]  = '{8'h07, 8'h07, 16'h4123, 8'h00, 1'b1, 1'b0};
        vt[5]  = '{8'h10, 8'hFF, 16'h7123, 8'h00, 1'b1, 1'b0};
        vt[6]  = '{8'h10, 8'h00, 16'h8123, 8'hFF, 1'b0, 1'b0};
        vt[7]  = '{8'hF0, 8'h0C, 16'h9123, 8'h03, 1'b0, 1'b0};
        vt[8]  = '{8'hF0, 8'h3C, 16'hA123, 8'hCF, 1'b0, 1'b0};
        vt[9]  = '{8'hAA, 8'hFF, 16'hB123, 8'h55, 1'b0, 1'b0};
        vt[10] = '{8'h12, 8'hFF, 16'hC123, 8'h00, 1'b1, 1'b0};
        vt[11] = '{8'h00, 8'h00, 16'h1AB3, 8'hAB, 1'b0, 1'b0};

        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_retire", 32'(retire), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_flags", {30'd0, zflag, cflag}, 0);
        chk("rst_w_reg", 32'(w_reg), 0);
        chk("rst_alu_out", 32'(alu_out), 0);
        chk("rst_opcode", 32'(opcode), 0);
        for (int i = 0; i < 16; i++) chk_reg($sformatf("rst_rf%0d", i), i, 8'h00);

        // Program load and run: retire cadence, result, halt position.
        load(0, 16'h1050); load(1, 16'h1031); load(2, 16'h2012); load(3, 16'h0000);
        run = 1'b1;
        for (int k = 1; k <= 40 && !halted; k++) begin
            tick();
            if (retire) rcyc.push_back(k);
        end
        run = 1'b0;
        chk("prog_retires", 32'(rcyc.size()), 4);
        for (int i = 0; i < rcyc.size() && i < 4; i++)
            chk($sformatf("prog_retire_cycle%0d", i), 32'(rcyc[i]), 32'(5 * (i + 1)));
        chk("prog_halted", 32'(halted), 1);
        chk("prog_pc", 32'(pc), 3);
        chk_reg("prog_r2", 2, 8'h08);

        // Reset during EX, then rerun from intact imem.
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("midex_busy_before", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run = 1'b0;
        chk("midex_busy", 32'(busy), 0);
        chk("midex_halted", 32'(halted), 0);
        chk("midex_pc", 32'(pc), 0);
        for (int i = 0; i < 16; i++) chk_reg($sformatf("midex_rf%0d", i), i, 8'h00);
        tick();
        chk("midex_stays_idle", 32'(busy), 0);
        run_to_halt("rerun");
        chk("rerun_pc", 32'(pc), 3);
        chk_reg("rerun_r2", 2, 8'h08);

        // Single-operation vector table: R1=a, R2=b, op writes R3.
        foreach (vt[i]) begin
            load(0, {4'h1, vt[i].a, 4'h1});
            load(1, {4'h1, vt[i].b, 4'h2});
            load(2, vt[i].ir);
            load(3, 16'h0000);
            do_reset();
            run_to_halt($sformatf("vec%0d", i));
            chk_reg($sformatf("vec%0d_rd", i), 3, vt[i].rd);
            chk($sformatf("vec%0d_z", i), 32'(zflag), 32'(vt[i].z));
            chk($sformatf("vec%0d_c", i), 32'(cflag), 32'(vt[i].c));
            chk($sformatf("vec%0d_pc", i), 32'(pc), 3);
        end

        // Carry and zero, then BZ taken.
        load(0, 16'h1FF0); load(1, 16'h3011); load(2, 16'hF002); load(3, 16'h0000); load(4, 16'h0000);
        do_reset();
        run_to_halt("cz");
        chk_reg("cz_r1", 1, 8'h00);
        chk("cz_z", 32'(zflag), 1);
        chk("cz_c", 32'(cflag), 1);
        chk("cz_bz_pc", 32'(pc), 4);

        // BGE taken (9>=9) and not taken (2<9).
        load(0, 16'h1091); load(1, 16'h1092); load(2, 16'h1003); load(3, 16'h1004);
        load(4, 16'hE123); load(5, 16'h0000); load(6, 16'h0000); load(7, 16'h0000);
        do_reset();
        run_to_halt("bge_t");
        chk("bge_taken_pc", 32'(pc), 7);
        load(0, 16'h1021);
        do_reset();
        run_to_halt("bge_nt");
        chk("bge_not_taken_pc", 32'(pc), 5);

        // JMP to top of imem, then pc+1 wraps to 0; single-step behaviour.
        load(0, 16'hDFF0); load(255, 16'h1011);
        do_reset();
        step_one(nret);
        chk("jmp_retires", 32'(nret), 1);
        chk("jmp_pc", 32'(pc), 32'hFF);
        chk("jmp_idle", {30'd0, busy, halted}, 0);
        step_one(nret);
        chk("wrap_retires", 32'(nret), 1);
        chk("wrap_pc", 32'(pc), 0);
        chk_reg("wrap_r1", 1, 8'h01);

        // Step held high through an instruction, with imem writes attempted while busy.
        load(0, 16'h1115); load(1, 16'h1225); load(2, 16'h0000);
        do_reset();
        nret = 0;
        step = 1'b1;
        tick();
        imem_we = 1'b1; imem_addr = 8'd1; imem_wdata = 16'h1335;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) imem_we = 1'b0;
            if (retire) nret++;
        end
        step = 1'b0;
        chk("held_idle", 32'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (retire || busy) nret++;
        end
        chk("held_one_instr", 32'(nret), 1);
        chk("held_pc", 32'(pc), 1);
        chk_reg("held_r5", 5, 8'h11);
        step_one(nret);
        chk_reg("busy_write_ignored", 5, 8'h22);
        chk("step2_pc", 32'(pc), 2);

        // MUL / DIV-by-zero, and flag preservation when the datapath is absent.
        load(0, 16'h1050); load(1, 16'h1071); load(2, 16'h1FF8); load(3, 16'h3819);
        load(4, 16'h5017); load(5, 16'h6026); load(6, 16'h0000);
        do_reset();
        run_to_halt("muldiv");
        chk("muldiv_pc", 32'(pc), 6);
`ifdef MCU_MULDIV_EN
        chk_reg("mul_r7", 7, 8'd35);
        chk_reg("div0_r6", 6, 8'hFF);
        chk("muldiv_flags", {30'd0, zflag, cflag}, 0);
`else
        chk_reg("mul_r7", 7, 8'h00);
        chk_reg("div0_r6", 6, 8'h00);
        chk("muldiv_flags", {30'd0, zflag, cflag}, 3);
`endif

        // Random programs, single-stepped against the reference model.
        for (int a = 0; a < 256; a++)
            load(a, {4'($urandom_range(1, 15)), 12'($urandom)});
        do_reset();
        m_pc = 0; m_z = 1'b0; m_c = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
        for (int n = 0; n < 150; n++) begin
            step_one(nret);
            model_exec();
            chk($sformatf("rnd%0d_retire", n), 32'(nret), 1);
            chk($sformatf("rnd%0d_pc", n), 32'(pc), 32'(m_pc));
            chk($sformatf("rnd%0d_flags", n), {30'd0, zflag, cflag}, {30'd0, m_z, m_c});
            for (int r = 0; r < 16; r++) begin
                rd_reg(r, v);
                chk($sformatf("rnd%0d_r%0d", n, r), 32'(v), 32'(m_rf[r]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
